// File: rtl/fifo_rd_stream_adapter_if.sv
// Stream handshake bundle between the adapter and its sink.
//   o_valid : beat valid (driven by the adapter)
//   o_data  : beat payload (driven by the adapter)
//   i_ready : sink ready (driven by the sink)
// Signal names are written from the adapter's point of view.
interface fifo_rd_stream_adapter_if #(
    parameter int unsigned DATA_WIDTH = 8
);
    logic                  o_valid;
    logic [DATA_WIDTH-1:0] o_data;
    logic                  i_ready;

    modport master (output o_valid, output o_data, input i_ready);
    modport slave  (input o_valid, input o_data, output i_ready);
endinterface

// File: rtl/fifo_rd_stream_adapter.sv
// Converts a fixed-latency FIFO read port into a valid/ready stream through a
// small skid buffer, sustaining one beat per cycle.
//
// Ports:
//   clk, rst_n      : clock (rising edge) and asynchronous active-low reset
//   i_clr           : synchronous flush, coincident with the upstream FIFO clear
//   i_fifo_empty    : upstream FIFO empty flag
//   i_fifo_rd_data  : upstream read data, valid RD_LATENCY cycles after o_fifo_rd_en
//   o_fifo_rd_en    : upstream read enable
//   o_idle          : buffer empty and no reads in flight
//   o_xfer_count    : accepted-beat counter (zero unless enabled)
//   stream          : master side of the valid/ready stream
//
// Optional feature: define FIFO_RD_STREAM_ADAPTER_XFER_CNT_EN to build the
// 32-bit accepted-beat counter; otherwise o_xfer_count is tied to zero.
module fifo_rd_stream_adapter #(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned RD_LATENCY = 1
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    i_clr,
    input  logic                    i_fifo_empty,
    input  logic [DATA_WIDTH-1:0]   i_fifo_rd_data,
    output logic                    o_fifo_rd_en,
    output logic                    o_idle,
    output logic [31:0]             o_xfer_count,
    fifo_rd_stream_adapter_if.master stream
);

    localparam int unsigned BUF_DEPTH = RD_LATENCY + 2;
    localparam int unsigned PTR_W     = $clog2(BUF_DEPTH);
    localparam int unsigned CNT_W     = $clog2(BUF_DEPTH + 1);
    localparam int unsigned SUM_W     = CNT_W + 1;
    localparam int unsigned XFER_W    = 32;

    logic [DATA_WIDTH-1:0] mem [BUF_DEPTH];
    logic [PTR_W-1:0]      wr_ptr;
    logic [PTR_W-1:0]      rd_ptr;
    logic [CNT_W-1:0]      occupancy;
    logic [CNT_W-1:0]      in_flight;
    logic [RD_LATENCY-1:0] pipe;

    logic                  capture;
    logic                  pop;
    logic [RD_LATENCY-1:0] pipe_nxt;
    logic [CNT_W-1:0]      occupancy_nxt;
    logic [CNT_W-1:0]      in_flight_nxt;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(BUF_DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    // Read issue, capture/pop strobes and next counts. Reads are gated only
    // by registered counts so i_ready never reaches o_fifo_rd_en; rst_n holds
    // the enable low while reset is asserted.
    always_comb begin
        capture       = pipe[RD_LATENCY-1];
        pop           = (occupancy != '0) && stream.i_ready;
        o_fifo_rd_en  = rst_n && !i_fifo_empty && !i_clr &&
                        ((SUM_W'(occupancy) + SUM_W'(in_flight)) < SUM_W'(BUF_DEPTH));
        pipe_nxt      = RD_LATENCY'({pipe, o_fifo_rd_en});
        occupancy_nxt = occupancy + CNT_W'(capture) - CNT_W'(pop);
        in_flight_nxt = in_flight + CNT_W'(o_fifo_rd_en) - CNT_W'(capture);
    end

    // Control state; a clear drops buffered beats and forgets in-flight reads.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            occupancy <= '0;
            in_flight <= '0;
            pipe      <= '0;
        end else if (i_clr) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            occupancy <= '0;
            in_flight <= '0;
            pipe      <= '0;
        end else begin
            pipe      <= pipe_nxt;
            occupancy <= occupancy_nxt;
            in_flight <= in_flight_nxt;
            if (capture) wr_ptr <= ptr_inc(wr_ptr);
            if (pop)     rd_ptr <= ptr_inc(rd_ptr);
        end
    end

    // Buffer storage, intentionally without reset.
    always_ff @(posedge clk) begin
        if (capture && !i_clr) mem[wr_ptr] <= i_fifo_rd_data;
    end

    assign stream.o_valid = (occupancy != '0);
    assign stream.o_data  = mem[rd_ptr];
    assign o_idle         = (occupancy == '0) && (in_flight == '0);

`ifdef FIFO_RD_STREAM_ADAPTER_XFER_CNT_EN
    logic [XFER_W-1:0] xfer_count;

    // Accepted-beat counter, wraps naturally at 2^32.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            xfer_count <= '0;
        end else if (i_clr) begin
            xfer_count <= '0;
        end else if (pop) begin
            xfer_count <= xfer_count + XFER_W'(1);
        end
    end

    assign o_xfer_count = xfer_count;
`else
    assign o_xfer_count = XFER_W'(0);
`endif

endmodule

// File: tb/tb_fifo_rd_stream_adapter.sv
// Bench for fifo_rd_stream_adapter: two instances (RD_LATENCY 1 and 2) run in
// lockstep on identical stimulus. Each has its own upstream FIFO model; the
// reference is a word-order scoreboard (words written, words read upstream,
// words delivered) from which read enable, idle and data are predicted.
module tb_fifo_rd_stream_adapter;

    localparam int unsigned DW    = 8;
    localparam int unsigned AW    = 12;
    localparam int unsigned MEM_N = 4096;
`ifdef FIFO_RD_STREAM_ADAPTER_XFER_CNT_EN
    localparam logic [31:0] XFER_MASK = 32'hFFFF_FFFF;
`else
    localparam logic [31:0] XFER_MASK = 32'h0;
`endif

    logic clk = 1'b0;
    logic rst_n;
    logic clr;
    logic ready;

    logic [1:0]          empty;
    logic [1:0]          rd_en;
    logic [1:0]          idle;
    logic [1:0]          valid;
    logic [1:0][DW-1:0]  data;
    logic [1:0][DW-1:0]  d1;
    logic [DW-1:0]       d2;
    logic [1:0][31:0]    xfer;

    always #5 clk = ~clk;

    fifo_rd_stream_adapter_if #(.DATA_WIDTH(DW)) s0 ();
    fifo_rd_stream_adapter_if #(.DATA_WIDTH(DW)) s1 ();

    assign s0.i_ready = ready;
    assign s1.i_ready = ready;
    assign valid[0]   = s0.o_valid;
    assign valid[1]   = s1.o_valid;
    assign data[0]    = s0.o_data;
    assign data[1]    = s1.o_data;

    fifo_rd_stream_adapter #(.DATA_WIDTH(DW), .RD_LATENCY(1)) dut0 (
        .clk            (clk),
        .rst_n          (rst_n),
        .i_clr          (clr),
        .i_fifo_empty   (empty[0]),
        .i_fifo_rd_data (d1[0]),
        .o_fifo_rd_en   (rd_en[0]),
        .o_idle         (idle[0]),
        .o_xfer_count   (xfer[0]),
        .stream         (s0)
    );

    fifo_rd_stream_adapter #(.DATA_WIDTH(DW), .RD_LATENCY(2)) dut1 (
        .clk            (clk),
        .rst_n          (rst_n),
        .i_clr          (clr),
        .i_fifo_empty   (empty[1]),
        .i_fifo_rd_data (d2),
        .o_fifo_rd_en   (rd_en[1]),
        .o_idle         (idle[1]),
        .o_xfer_count   (xfer[1]),
        .stream         (s1)
    );

    // Scoreboard: words [0, up_wr) written upstream, [0, up_rd) read by the
    // adapter, [0, exp_rd) delivered on the stream.
    logic [DW-1:0] mem [2][MEM_N];
    int            up_wr  [2];
    int            up_rd  [2];
    int            exp_rd [2];
    logic [31:0]   xfer_exp [2];

    int compared = 0;
    int mism     = 0;
    int cyc_no   = 0;
    int beat_cnt   [2];
    int first_beat [2];
    int last_beat  [2];
    int rd_cnt     [2];
    int max_outst  [2];
    logic          hold_prev [2];
    logic [DW-1:0] prev_data [2];

    // Upstream FIFO models: fixed read latency of 1 (dut0) and 2 (dut1).
    always @(posedge clk) begin
        for (int k = 0; k < 2; k++) begin
            if (!rst_n || clr) begin
                up_rd[k] <= up_wr[k];
            end else if (rd_en[k]) begin
                d1[k]    <= mem[k][AW'(up_rd[k])];
                up_rd[k] <= up_rd[k] + 1;
            end
        end
        d2 <= d1[1];
    end

    function automatic int depth_of(input int k);
        return (k == 0) ? 3 : 4;
    endfunction

    task automatic chk(input string tag, input int k, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mism++;
            $error("FAIL %s dut%0d observed=%0h expected=%0h", tag, k, obs, exp);
        end
    endtask

    task automatic push(input logic [DW-1:0] w);
        for (int k = 0; k < 2; k++) begin
            mem[k][AW'(up_wr[k])] = w;
            up_wr[k]++;
        end
    endtask

    task automatic clear_stats();
        for (int k = 0; k < 2; k++) begin
            beat_cnt[k]   = 0;
            first_beat[k] = 0;
            last_beat[k]  = 0;
            rd_cnt[k]     = 0;
            max_outst[k]  = 0;
        end
    endtask

    task automatic flush_model();
        for (int k = 0; k < 2; k++) begin
            exp_rd[k]    = up_wr[k];
            xfer_exp[k]  = 32'd0;
            hold_prev[k] = 1'b0;
        end
    endtask

    // One clock cycle, entered and left at a falling edge: drive, predict,
    // check, then advance.
    task automatic cyc(input logic rdy, input logic c);
        int outst;
        ready = rdy;
        clr   = c;
        for (int k = 0; k < 2; k++) empty[k] = (up_rd[k] == up_wr[k]);
        #1;
        for (int k = 0; k < 2; k++) begin
            outst = up_rd[k] - exp_rd[k];
            chk("idle", k, 32'(idle[k]), 32'(outst == 0));
            chk("rd_en", k, 32'(rd_en[k]), 32'(!empty[k] && !c && (outst < depth_of(k))));
            chk("xfer_count", k, xfer[k], xfer_exp[k] & XFER_MASK);
            if (hold_prev[k]) begin
                chk("hold_valid", k, 32'(valid[k]), 32'd1);
                chk("hold_data", k, 32'(data[k]), 32'(prev_data[k]));
            end
            if (rd_en[k]) rd_cnt[k]++;
            if (outst + int'(rd_en[k]) > max_outst[k]) max_outst[k] = outst + int'(rd_en[k]);
            if (valid[k] && rdy) begin
                chk("data", k, 32'(data[k]), 32'(mem[k][AW'(exp_rd[k])]));
                exp_rd[k]++;
                xfer_exp[k] = xfer_exp[k] + 32'd1;
                if (beat_cnt[k] == 0) first_beat[k] = cyc_no;
                last_beat[k] = cyc_no;
                beat_cnt[k]++;
            end
            hold_prev[k] = valid[k] && !rdy && !c;
            prev_data[k] = data[k];
        end
        if (c) flush_model();
        cyc_no++;
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        int start;
        int pushed;
        int guard;
        int n;

        rst_n = 1'b1;
        clr   = 1'b0;
        ready = 1'b0;
        for (int k = 0; k < 2; k++) begin
            up_wr[k] = 0;
            empty[k] = 1'b1;
        end
        flush_model();
        clear_stats();

        // Reset values with a non-empty upstream FIFO.
        #1 rst_n = 1'b0;
        push(8'hA5);
        push(8'h5A);
        for (int k = 0; k < 2; k++) empty[k] = 1'b0;
        #1;
        for (int k = 0; k < 2; k++) begin
            chk("rst_valid", k, 32'(valid[k]), 32'd0);
            chk("rst_rd_en", k, 32'(rd_en[k]), 32'd0);
            chk("rst_idle", k, 32'(idle[k]), 32'd1);
            chk("rst_xfer", k, xfer[k], 32'd0);
        end
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        flush_model();

        // Streaming: 16 words, sink always ready.
        clear_stats();
        start = cyc_no;
        for (int i = 0; i < 16; i++) push(DW'(i));
        for (int i = 0; i < 25; i++) cyc(1'b1, 1'b0);
        for (int k = 0; k < 2; k++) begin
            chk("stream_beats", k, 32'(beat_cnt[k]), 32'd16);
            chk("stream_first_lat", k, 32'(first_beat[k] - start), 32'(k + 2));
            chk("stream_span", k, 32'(last_beat[k] - first_beat[k]), 32'd15);
            chk("stream_xfer", k, xfer[k], 32'd16 & XFER_MASK);
        end

        // Backpressure: reads stop at buffer depth, then in-order drain.
        clear_stats();
        for (int i = 0; i < 10; i++) push(DW'(8'h40 + i));
        for (int i = 0; i < 12; i++) cyc(1'b0, 1'b0);
        for (int k = 0; k < 2; k++) chk("bp_reads", k, 32'(rd_cnt[k]), 32'(depth_of(k)));
        for (int i = 0; i < 20; i++) cyc(1'b1, 1'b0);
        for (int k = 0; k < 2; k++) begin
            chk("bp_beats", k, 32'(beat_cnt[k]), 32'd10);
            chk("bp_drained", k, 32'(exp_rd[k]), 32'(up_wr[k]));
        end

        // Clear with a full buffer (dut1: 3 buffered + 1 in flight).
        clear_stats();
        for (int i = 0; i < 8; i++) push(DW'(8'h80 + i));
        for (int i = 0; i < 5; i++) cyc(1'b0, 1'b0);
        cyc(1'b0, 1'b1);
        for (int k = 0; k < 2; k++) begin
            chk("clr_valid", k, 32'(valid[k]), 32'd0);
            chk("clr_idle", k, 32'(idle[k]), 32'd1);
            chk("clr_xfer", k, xfer[k], 32'd0);
        end
        clear_stats();
        for (int i = 0; i < 4; i++) push(DW'(8'hC0 + i));
        for (int i = 0; i < 12; i++) cyc(1'b1, 1'b0);
        for (int k = 0; k < 2; k++) chk("clr_new_beats", k, 32'(beat_cnt[k]), 32'd4);

        // Upstream empty for 10 cycles.
        clear_stats();
        for (int i = 0; i < 10; i++) cyc(1'b1, 1'b0);
        for (int k = 0; k < 2; k++) begin
            chk("empty_reads", k, 32'(rd_cnt[k]), 32'd0);
            chk("empty_valid", k, 32'(valid[k]), 32'd0);
        end

        // Asynchronous reset dropped between clock edges mid-stream.
        for (int i = 0; i < 8; i++) push(DW'(8'hE0 + i));
        for (int i = 0; i < 4; i++) cyc(1'b1, 1'b0);
        for (int k = 0; k < 2; k++) chk("pre_arst_valid", k, 32'(valid[k]), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        for (int k = 0; k < 2; k++) begin
            chk("arst_valid", k, 32'(valid[k]), 32'd0);
            chk("arst_rd_en", k, 32'(rd_en[k]), 32'd0);
            chk("arst_idle", k, 32'(idle[k]), 32'd1);
        end
        flush_model();
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 5; i++) cyc(1'b1, 1'b0);

        // Random sink readiness over 1000 words with bursty upstream writes.
        clear_stats();
        pushed = 0;
        guard  = 0;
        while ((pushed < 1000 || exp_rd[0] != up_wr[0] || exp_rd[1] != up_wr[1]) && guard < 8000) begin
            n = int'($urandom_range(0, 2));
            for (int j = 0; j < n; j++) begin
                if (pushed < 1000) begin
                    push(DW'($urandom));
                    pushed++;
                end
            end
            cyc(1'($urandom_range(0, 1)), 1'b0);
            guard++;
        end
        chk("rand_done", 0, 32'(guard < 8000), 32'd1);
        for (int k = 0; k < 2; k++) begin
            chk("rand_beats", k, 32'(beat_cnt[k]), 32'd1000);
            chk("rand_max_outst", k, 32'(max_outst[k] <= depth_of(k)), 32'd1);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mism);
        $finish;
    end

endmodule
